// File: rtl/bpu_pkg.sv
// Shared types for the branch resolve/update path: branch encodings, PHT counter
// states, metadata slot layout and the registered update bundle.
package bpu_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned PHT_IDX_W = 11;
  localparam int unsigned CNT_W     = 2;
  localparam int unsigned BR_TYPE_W = 2;

  typedef enum logic [BR_TYPE_W-1:0] {
    BR_COND = 2'b00,
    BR_JAL  = 2'b01,
    BR_JALR = 2'b10,
    BR_RET  = 2'b11
  } br_type_e;

  typedef enum logic [CNT_W-1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } cnt_e;

  typedef struct packed {
    logic                 valid;
    logic [XLEN-1:0]      pc;
    logic                 pred_taken;
    logic [XLEN-1:0]      pred_target;
    logic [PHT_IDX_W-1:0] pht_idx;
    logic [CNT_W-1:0]     pht_data;
  } meta_t;

  typedef struct packed {
    logic                 mispredict;
    logic [XLEN-1:0]      redirect_pc;
    logic                 pht_en;
    logic [PHT_IDX_W-1:0] pht_idx;
    logic [CNT_W-1:0]     pht_data;
    logic                 ghr_en;
    logic                 ghr_data;
    logic                 btb_en;
    logic [XLEN-1:0]      btb_addr;
    logic [XLEN-1:0]      btb_data;
    logic                 ras_call;
    logic [XLEN-1:0]      ras_npc;
    logic                 ras_ret;
  } upd_t;

  // Saturating 2-bit direction counter step.
  function automatic logic [CNT_W-1:0] cnt_update(input logic [CNT_W-1:0] cnt,
                                                  input logic             taken);
    if (taken) return (cnt == CNT_W'(ST)) ? cnt : cnt + CNT_W'(1);
    return (cnt == CNT_W'(SNT)) ? cnt : cnt - CNT_W'(1);
  endfunction

endpackage

// File: rtl/bpu_meta_pipe.sv
// Prediction metadata shift register from IF down to EX; clear beats stall and shift.
module bpu_meta_pipe
  import bpu_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  stall_i,
  input  logic  clear_i,
  input  meta_t in_i,
  output meta_t tail_o
);

  meta_t slot_q [DEPTH];
  meta_t slot_d [DEPTH];

  always_comb begin
    slot_d = slot_q;
    if (clear_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) slot_d[i].valid = 1'b0;
    end else if (!stall_i) begin
      slot_d[0] = in_i;
      for (int unsigned i = 1; i < DEPTH; i++) slot_d[i] = slot_q[i-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) slot_q[i] <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign tail_o = slot_q[DEPTH-1];

endmodule

// File: rtl/bpu_resolve_update.sv
// Resolves EX control flow against carried fetch-time predictions and registers
// the mispredict redirect plus PHT/GHR/BTB/RAS update strobes.
module bpu_resolve_update
  import bpu_pkg::*;
#(
  parameter int unsigned META_DEPTH = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 Stall,
  input  logic                 Flush,
  input  logic                 IF_Valid,
  input  logic [XLEN-1:0]      IF_PC,
  input  logic                 IF_Pred_Taken,
  input  logic [XLEN-1:0]      IF_Pred_Target,
  input  logic [PHT_IDX_W-1:0] IF_PHT_Index,
  input  logic [CNT_W-1:0]     IF_PHT_Data,
  input  logic                 EX_Valid,
  input  logic [XLEN-1:0]      EX_PC,
  input  logic                 EX_Is_Ctrl,
  input  logic [BR_TYPE_W-1:0] EX_Br_Type,
  input  logic                 EX_Is_Call,
  input  logic                 EX_Taken,
  input  logic [XLEN-1:0]      EX_Target,
  output logic                 Mispredict,
  output logic [XLEN-1:0]      Redirect_PC,
  output logic [PHT_IDX_W-1:0] PHT_Write_Index,
  output logic [CNT_W-1:0]     PHT_Write_Data,
  output logic                 PHT_Write_En,
  output logic                 GHR_Write_Data,
  output logic                 GHR_Write_En,
  output logic [XLEN-1:0]      BTB_Write_Addr,
  output logic [XLEN-1:0]      BTB_Write_Data,
  output logic                 BTB_Write_En,
  output logic                 RAS_CALL_Inst,
  output logic [XLEN-1:0]      RAS_CALL_Inst_nextPC,
  output logic                 RAS_RET_Inst_EX
);

  meta_t if_meta;
  meta_t ex_meta;
  upd_t  upd_q;
  upd_t  upd_d;

  logic                 hit;
  logic                 pred_taken;
  logic [XLEN-1:0]      pred_target;
  logic [PHT_IDX_W-1:0] pred_idx;
  logic [CNT_W-1:0]     pred_cnt;
  logic                 resolve;
  logic                 is_cond;
  logic                 tgt_wrong;
  logic [XLEN-1:0]      seq_pc;

  assign if_meta = '{valid: IF_Valid, pc: IF_PC, pred_taken: IF_Pred_Taken,
                     pred_target: IF_Pred_Target, pht_idx: IF_PHT_Index,
                     pht_data: IF_PHT_Data};

  bpu_meta_pipe #(.DEPTH(META_DEPTH)) u_meta_pipe (
    .clk_i   (CLK),
    .rst_i   (RST),
    .stall_i (Stall),
    .clear_i (Flush | upd_q.mispredict),
    .in_i    (if_meta),
    .tail_o  (ex_meta)
  );

  // A stale or foreign slot degrades to "predicted not taken, counter 0".
  assign hit         = ex_meta.valid & (ex_meta.pc == EX_PC);
  assign pred_taken  = hit & ex_meta.pred_taken;
  assign pred_target = hit ? ex_meta.pred_target : '0;
  assign pred_idx    = hit ? ex_meta.pht_idx : '0;
  assign pred_cnt    = hit ? ex_meta.pht_data : '0;

  assign resolve   = EX_Valid & ~Stall & ~upd_q.mispredict;
  assign is_cond   = EX_Is_Ctrl & (EX_Br_Type == BR_COND);
  assign tgt_wrong = (pred_target != EX_Target);
  assign seq_pc    = EX_PC + XLEN'(4);

  always_comb begin
    upd_d = '0;
    if (resolve) begin
      upd_d.mispredict  = EX_Is_Ctrl ? ((pred_taken != EX_Taken) | (EX_Taken & tgt_wrong))
                                     : pred_taken;
      upd_d.redirect_pc = (EX_Taken & EX_Is_Ctrl) ? EX_Target : seq_pc;
      if (is_cond) begin
        upd_d.pht_en   = 1'b1;
        upd_d.pht_idx  = pred_idx;
        upd_d.pht_data = cnt_update(pred_cnt, EX_Taken);
        upd_d.ghr_en   = 1'b1;
        upd_d.ghr_data = EX_Taken;
      end
      if (EX_Is_Ctrl & EX_Taken & (~pred_taken | tgt_wrong)) begin
        upd_d.btb_en   = 1'b1;
        upd_d.btb_addr = EX_PC;
        upd_d.btb_data = {EX_Target[XLEN-1:2], EX_Br_Type};
      end
      if (EX_Is_Ctrl & EX_Is_Call) begin
        upd_d.ras_call = 1'b1;
        upd_d.ras_npc  = seq_pc;
      end
      upd_d.ras_ret = EX_Is_Ctrl & (EX_Br_Type == BR_RET);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) upd_q <= '0;
    else     upd_q <= upd_d;
  end

  assign Mispredict           = upd_q.mispredict;
  assign Redirect_PC          = upd_q.redirect_pc;
  assign PHT_Write_Index      = upd_q.pht_idx;
  assign PHT_Write_Data       = upd_q.pht_data;
  assign PHT_Write_En         = upd_q.pht_en;
  assign GHR_Write_Data       = upd_q.ghr_data;
  assign GHR_Write_En         = upd_q.ghr_en;
  assign BTB_Write_Addr       = upd_q.btb_addr;
  assign BTB_Write_Data       = upd_q.btb_data;
  assign BTB_Write_En         = upd_q.btb_en;
  assign RAS_CALL_Inst        = upd_q.ras_call;
  assign RAS_CALL_Inst_nextPC = upd_q.ras_npc;
  assign RAS_RET_Inst_EX      = upd_q.ras_ret;

endmodule

// File: tb/tb_bpu_resolve_update.sv
// Directed scenarios plus randomized traffic against a fetch-history reference model.
module tb_bpu_resolve_update;

  localparam int unsigned D = 2;

  logic        CLK = 1'b0;
  logic        RST, Stall, Flush;
  logic        IF_Valid, IF_Pred_Taken;
  logic [31:0] IF_PC, IF_Pred_Target;
  logic [10:0] IF_PHT_Index;
  logic [1:0]  IF_PHT_Data;
  logic        EX_Valid, EX_Is_Ctrl, EX_Is_Call, EX_Taken;
  logic [31:0] EX_PC, EX_Target;
  logic [1:0]  EX_Br_Type;
  logic        Mispredict, PHT_Write_En, GHR_Write_Data, GHR_Write_En, BTB_Write_En;
  logic        RAS_CALL_Inst, RAS_RET_Inst_EX;
  logic [31:0] Redirect_PC, BTB_Write_Addr, BTB_Write_Data, RAS_CALL_Inst_nextPC;
  logic [10:0] PHT_Write_Index;
  logic [1:0]  PHT_Write_Data;

  always #5 CLK = ~CLK;

  bpu_resolve_update #(.META_DEPTH(D)) dut (
    .CLK(CLK), .RST(RST), .Stall(Stall), .Flush(Flush),
    .IF_Valid(IF_Valid), .IF_PC(IF_PC), .IF_Pred_Taken(IF_Pred_Taken),
    .IF_Pred_Target(IF_Pred_Target), .IF_PHT_Index(IF_PHT_Index), .IF_PHT_Data(IF_PHT_Data),
    .EX_Valid(EX_Valid), .EX_PC(EX_PC), .EX_Is_Ctrl(EX_Is_Ctrl), .EX_Br_Type(EX_Br_Type),
    .EX_Is_Call(EX_Is_Call), .EX_Taken(EX_Taken), .EX_Target(EX_Target),
    .Mispredict(Mispredict), .Redirect_PC(Redirect_PC),
    .PHT_Write_Index(PHT_Write_Index), .PHT_Write_Data(PHT_Write_Data),
    .PHT_Write_En(PHT_Write_En), .GHR_Write_Data(GHR_Write_Data), .GHR_Write_En(GHR_Write_En),
    .BTB_Write_Addr(BTB_Write_Addr), .BTB_Write_Data(BTB_Write_Data), .BTB_Write_En(BTB_Write_En),
    .RAS_CALL_Inst(RAS_CALL_Inst), .RAS_CALL_Inst_nextPC(RAS_CALL_Inst_nextPC),
    .RAS_RET_Inst_EX(RAS_RET_Inst_EX)
  );

  typedef struct {
    bit        v;
    bit [31:0] pc;
    bit        pt;
    bit [31:0] tgt;
    bit [10:0] idx;
    bit [1:0]  cnt;
  } rec_t;

  typedef struct {
    bit        res, misp, pht_en, ghr_en, ghr_d, btb_en, call, ret;
    bit [31:0] rpc, baddr, bdata, npc;
    bit [10:0] pidx;
    bit [1:0]  pdat;
  } exp_t;

  rec_t hist[$];   // last D fetches, oldest first; hist[0] is what EX sees
  exp_t e;
  bit   m_misp;
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Predict next-cycle outputs from the current inputs, then advance fetch history.
  task automatic model();
    exp_t n;
    rec_t r;
    n = '{default: '0};
    if (RST) begin
      hist.delete();
      repeat (D) hist.push_back('{default: '0});
      m_misp = 1'b0;
      e = n;
      return;
    end
    r = hist[0];
    if (!(r.v && r.pc == EX_PC)) r = '{default: '0};
    if (EX_Valid && !Stall && !m_misp) begin
      n.res  = 1'b1;
      n.misp = EX_Is_Ctrl ? ((r.pt != EX_Taken) || (EX_Taken && r.tgt != EX_Target)) : r.pt;
      n.rpc  = (EX_Is_Ctrl && EX_Taken) ? EX_Target : EX_PC + 32'd4;
      if (EX_Is_Ctrl && EX_Br_Type == 2'd0) begin
        n.pht_en = 1'b1;
        n.pidx   = r.idx;
        n.pdat   = EX_Taken ? ((r.cnt == 2'd3) ? 2'd3 : r.cnt + 2'd1)
                            : ((r.cnt == 2'd0) ? 2'd0 : r.cnt - 2'd1);
        n.ghr_en = 1'b1;
        n.ghr_d  = EX_Taken;
      end
      if (EX_Is_Ctrl && EX_Taken && (!r.pt || r.tgt != EX_Target)) begin
        n.btb_en = 1'b1;
        n.baddr  = EX_PC;
        n.bdata  = {EX_Target[31:2], EX_Br_Type};
      end
      if (EX_Is_Ctrl && EX_Is_Call) begin
        n.call = 1'b1;
        n.npc  = EX_PC + 32'd4;
      end
      n.ret = EX_Is_Ctrl && (EX_Br_Type == 2'd3);
    end
    if (Flush || m_misp) begin
      foreach (hist[i]) hist[i].v = 1'b0;
    end else if (!Stall) begin
      hist.push_back('{v: IF_Valid, pc: IF_PC, pt: IF_Pred_Taken, tgt: IF_Pred_Target,
                       idx: IF_PHT_Index, cnt: IF_PHT_Data});
      void'(hist.pop_front());
    end
    m_misp = n.misp;
    e = n;
  endtask

  task automatic step();
    model();
    @(posedge CLK);
    @(negedge CLK);
    chk("misp",    32'(Mispredict),      32'(e.misp));
    chk("pht_en",  32'(PHT_Write_En),    32'(e.pht_en));
    chk("ghr_en",  32'(GHR_Write_En),    32'(e.ghr_en));
    chk("btb_en",  32'(BTB_Write_En),    32'(e.btb_en));
    chk("ras_call",32'(RAS_CALL_Inst),   32'(e.call));
    chk("ras_ret", 32'(RAS_RET_Inst_EX), 32'(e.ret));
    if (e.res)    chk("redirect", Redirect_PC, e.rpc);
    if (e.pht_en) chk("pht_idx",  32'(PHT_Write_Index), 32'(e.pidx));
    if (e.pht_en) chk("pht_data", 32'(PHT_Write_Data),  32'(e.pdat));
    if (e.ghr_en) chk("ghr_data", 32'(GHR_Write_Data),  32'(e.ghr_d));
    if (e.btb_en) chk("btb_addr", BTB_Write_Addr, e.baddr);
    if (e.btb_en) chk("btb_data", BTB_Write_Data, e.bdata);
    if (e.call)   chk("ras_npc",  RAS_CALL_Inst_nextPC, e.npc);
  endtask

  task automatic drv_if(input bit v, input bit [31:0] pc, input bit pt, input bit [31:0] tgt,
                        input bit [10:0] idx, input bit [1:0] cnt);
    IF_Valid = v; IF_PC = pc; IF_Pred_Taken = pt; IF_Pred_Target = tgt;
    IF_PHT_Index = idx; IF_PHT_Data = cnt;
  endtask

  task automatic drv_ex(input bit v, input bit [31:0] pc, input bit ctrl, input bit [1:0] ty,
                        input bit call, input bit tk, input bit [31:0] tgt);
    EX_Valid = v; EX_PC = pc; EX_Is_Ctrl = ctrl; EX_Br_Type = ty;
    EX_Is_Call = call; EX_Taken = tk; EX_Target = tgt;
  endtask

  task automatic idle();
    drv_if(1'b0, 32'd0, 1'b0, 32'd0, 11'd0, 2'd0);
    drv_ex(1'b0, 32'd0, 1'b0, 2'd1, 1'b0, 1'b0, 32'd0);
  endtask

  initial begin
    RST = 1'b1; Stall = 1'b0; Flush = 1'b0;
    idle();
    step(); step();
    RST = 1'b0;
    step();
    chk("rst_redirect", Redirect_PC, 32'd0);

    // predicted-taken cond branch resolves as predicted
    drv_if(1'b1, 32'h100, 1'b1, 32'h200, 11'd5, 2'd2); step();
    idle(); step();
    drv_ex(1'b1, 32'h100, 1'b1, 2'd0, 1'b0, 1'b1, 32'h200); step();
    chk("d1_pht_en", 32'(PHT_Write_En), 32'd1);
    chk("d1_pht_data", 32'(PHT_Write_Data), 32'd3);
    chk("d1_misp", 32'(Mispredict), 32'd0);
    chk("d1_btb_en", 32'(BTB_Write_En), 32'd0);

    // strongly-taken branch falls through; younger fetch must be squashed
    drv_if(1'b1, 32'h100, 1'b1, 32'h200, 11'd6, 2'd3); drv_ex(1'b0, 32'd0, 1'b0, 2'd1, 1'b0, 1'b0, 32'd0); step();
    idle(); step();
    drv_if(1'b1, 32'h500, 1'b1, 32'h600, 11'd0, 2'd0);
    drv_ex(1'b1, 32'h100, 1'b1, 2'd0, 1'b0, 1'b0, 32'h200); step();
    chk("d2_misp", 32'(Mispredict), 32'd1);
    chk("d2_redirect", Redirect_PC, 32'h104);
    chk("d2_pht_data", 32'(PHT_Write_Data), 32'd2);
    chk("d2_ghr_data", 32'(GHR_Write_Data), 32'd0);
    idle(); step();
    drv_ex(1'b1, 32'h500, 1'b0, 2'd1, 1'b0, 1'b0, 32'd0); step();
    chk("d2_squashed", 32'(Mispredict), 32'd0);

    // unpredicted jal with link
    idle(); drv_ex(1'b1, 32'h40, 1'b1, 2'd1, 1'b1, 1'b1, 32'h80); step();
    chk("d3_misp", 32'(Mispredict), 32'd1);
    chk("d3_redirect", Redirect_PC, 32'h80);
    chk("d3_btb_addr", BTB_Write_Addr, 32'h40);
    chk("d3_btb_data", BTB_Write_Data, 32'h81);
    chk("d3_call", 32'(RAS_CALL_Inst), 32'd1);
    chk("d3_npc", RAS_CALL_Inst_nextPC, 32'h44);
    idle(); step();

    // return predicted to wrong target
    drv_if(1'b1, 32'h60, 1'b1, 32'h44, 11'd0, 2'd0); step();
    idle(); step();
    drv_ex(1'b1, 32'h60, 1'b1, 2'd3, 1'b0, 1'b1, 32'h48); step();
    chk("d4_misp", 32'(Mispredict), 32'd1);
    chk("d4_btb_data", BTB_Write_Data, 32'h4B);
    chk("d4_ret", 32'(RAS_RET_Inst_EX), 32'd1);
    idle(); step();

    // stall with a branch sitting in EX
    drv_if(1'b1, 32'h100, 1'b0, 32'd0, 11'd7, 2'd1); step();
    idle(); step();
    drv_ex(1'b1, 32'h100, 1'b1, 2'd0, 1'b0, 1'b1, 32'h120);
    Stall = 1'b1;
    repeat (3) begin
      step();
      chk("d5_stall_pht", 32'(PHT_Write_En), 32'd0);
    end
    Stall = 1'b0; step();
    chk("d5_release_pht", 32'(PHT_Write_En), 32'd1);
    chk("d5_release_data", 32'(PHT_Write_Data), 32'd2);
    idle(); step();

    // external flush drops the carried prediction
    drv_if(1'b1, 32'h300, 1'b1, 32'h340, 11'd9, 2'd3); step();
    idle(); Flush = 1'b1; step();
    Flush = 1'b0;
    drv_ex(1'b1, 32'h300, 1'b1, 2'd0, 1'b0, 1'b1, 32'h340); step();
    chk("d6_flush_misp", 32'(Mispredict), 32'd1);
    chk("d6_flush_idx", 32'(PHT_Write_Index), 32'd0);
    chk("d6_flush_data", 32'(PHT_Write_Data), 32'd1);
    idle(); step();

    // counter saturation at both ends
    drv_if(1'b1, 32'h180, 1'b0, 32'd0, 11'd3, 2'd0); step();
    idle(); step();
    drv_ex(1'b1, 32'h180, 1'b1, 2'd0, 1'b0, 1'b0, 32'd0); step();
    chk("d7_sat_lo", 32'(PHT_Write_Data), 32'd0);
    drv_if(1'b1, 32'h1C0, 1'b1, 32'h1F0, 11'd4, 2'd3); drv_ex(1'b0, 32'd0, 1'b0, 2'd1, 1'b0, 1'b0, 32'd0); step();
    idle(); step();
    drv_ex(1'b1, 32'h1C0, 1'b1, 2'd0, 1'b0, 1'b1, 32'h1F0); step();
    chk("d7_sat_hi", 32'(PHT_Write_Data), 32'd3);
    chk("d7_hit_misp", 32'(Mispredict), 32'd0);

    // sequential PC wraps
    idle(); drv_ex(1'b1, 32'hFFFF_FFFC, 1'b0, 2'd1, 1'b0, 1'b0, 32'd0); step();
    chk("d8_wrap", Redirect_PC, 32'd0);

    // reset during a resolving cycle
    drv_if(1'b1, 32'h100, 1'b0, 32'd0, 11'd1, 2'd1); drv_ex(1'b0, 32'd0, 1'b0, 2'd1, 1'b0, 1'b0, 32'd0); step();
    idle(); step();
    drv_ex(1'b1, 32'h100, 1'b1, 2'd0, 1'b0, 1'b1, 32'h200);
    RST = 1'b1; step();
    chk("d9_rst_pht", 32'(PHT_Write_En), 32'd0);
    chk("d9_rst_btb", 32'(BTB_Write_En), 32'd0);
    RST = 1'b0; idle(); step();

    for (int n = 0; n < 600; n++) begin
      rec_t s;
      bit ctrl, tk, call;
      bit [1:0] ty;
      s     = hist[0];
      RST   = ($urandom_range(99) == 0);
      Stall = ($urandom_range(9) == 0);
      Flush = ($urandom_range(19) == 0);
      drv_if($urandom_range(3) != 0, 32'($urandom_range(63)) << 2, 1'($urandom_range(1)),
             32'($urandom_range(63)) << 2, 11'($urandom), 2'($urandom_range(3)));
      ctrl = ($urandom_range(3) != 0);
      ty   = ctrl ? 2'($urandom_range(3)) : 2'd1;
      tk   = ctrl && ((ty != 2'd0) || ($urandom_range(1) == 1));
      call = ctrl && (ty == 2'd1 || ty == 2'd2) && ($urandom_range(1) == 1);
      drv_ex($urandom_range(4) != 0,
             ($urandom_range(9) < 7) ? s.pc : 32'($urandom_range(63)) << 2,
             ctrl, ty, call, tk,
             ($urandom_range(1) == 1) ? s.tgt : 32'($urandom_range(63)) << 2);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
